// File: rtl/vram_link_pkg.sv
// Shared types and constants for the 2-bit cartridge video/sound link.
// Used by the transmitter, its phase generator and the link interface.
package vram_link_pkg;

    localparam int LINK_NUM_PIXELS  = 19200;
    localparam int LINK_SOUND_SLOTS = 8;
    localparam int LINK_SOUND_W     = 16;
    localparam int LINK_PIX_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOUND,
        ST_PIXELS,
        ST_DONE
    } link_state_e;

    // Sound slot k carries bits [15-2k:14-2k] of the word.
    function automatic logic [LINK_PIX_W-1:0] sound_slot(
        input logic [LINK_SOUND_W-1:0] w,
        input logic [2:0]              k
    );
        logic [LINK_SOUND_W-1:0] s;
        s = w >> (4'd14 - {k, 1'b0});
        return s[LINK_PIX_W-1:0];
    endfunction

endpackage

// File: rtl/vram_link_tx_if.sv
// Renderer-side handshake plus link pins of the video/sound transmitter.
// master = renderer/driver side, slave = transmitter.
interface vram_link_tx_if;
    import vram_link_pkg::*;

    logic                    start;
    logic [LINK_SOUND_W-1:0] sound_in;
    logic [LINK_PIX_W-1:0]   pix_data;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    wclk;
    logic [LINK_PIX_W-1:0]   din;
    logic                    write_en;
    logic                    busy;
    logic                    done;

    modport master (
        output start, sound_in, pix_data, pix_valid,
        input  pix_ready, wclk, din, write_en, busy, done
    );

    modport slave (
        input  start, sound_in, pix_data, pix_valid,
        output pix_ready, wclk, din, write_en, busy, done
    );

endinterface

// File: rtl/link_phase_gen.sv
// Slot timer: CLK_DIV cycles of wclk low, then CLK_DIV cycles high.
// A new slot starts only on go without stall once the previous one ends.
module link_phase_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic stall,
    output logic wclk,
    output logic low_start,
    output logic slot_end,
    output logic slot_free
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wclk_q, wclk_d;
    logic          act_q, act_d;

    assign slot_end  = act_q & wclk_q & (cnt_q == LAST);
    assign slot_free = ~act_q | slot_end;
    assign low_start = go & ~stall & slot_free;
    assign wclk      = wclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        wclk_d = wclk_q;
        act_d  = act_q;
        if (low_start) begin
            cnt_d  = '0;
            wclk_d = 1'b0;
            act_d  = 1'b1;
        end else if (act_q) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                // Idle after the high phase keeps wclk low with no edge.
                if (wclk_q) begin
                    wclk_d = 1'b0;
                    act_d  = 1'b0;
                end else begin
                    wclk_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wclk_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wclk_q <= wclk_d;
            act_q  <= act_d;
        end
    end

endmodule

// File: rtl/vram_link_tx.sv
// Host-side transmitter: 8 sound slots then NUM_PIXELS pixel slots per frame
// on the 2-bit wclk/din/write_en link.
module vram_link_tx
    import vram_link_pkg::*;
#(
    parameter int NUM_PIXELS = LINK_NUM_PIXELS,
    parameter int CLK_DIV    = 4
) (
    input  logic          clk,
    input  logic          rst,
    vram_link_tx_if.slave link
);

    localparam int PCW = $clog2(NUM_PIXELS + 1);
    localparam logic [PCW-1:0] LAST_PIX = PCW'(NUM_PIXELS - 1);
    localparam int SW = $clog2(LINK_SOUND_SLOTS);
    localparam logic [SW-1:0] LAST_SND = SW'(LINK_SOUND_SLOTS - 1);

    link_state_e             state_q, state_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [PCW-1:0]          pix_cnt_q, pix_cnt_d;
    logic [LINK_SOUND_W-1:0] sound_q, sound_d;
    logic [LINK_PIX_W-1:0]   din_q, din_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic need_pix;
    logic go;
    logic stall;
    logic wclk;
    logic low_start;
    logic slot_end;
    logic slot_free;

    link_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .stall     (stall),
        .wclk      (wclk),
        .low_start (low_start),
        .slot_end  (slot_end),
        .slot_free (slot_free)
    );

    // The next slot needs a pixel: last sound slot or a non-final pixel slot.
    always_comb begin
        need_pix = 1'b0;
        go       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                go = link.start;
            end
            ST_SOUND: begin
                need_pix = (slot_q == LAST_SND);
                go       = 1'b1;
            end
            ST_PIXELS: begin
                need_pix = (pix_cnt_q != LAST_PIX);
                go       = need_pix;
            end
            default: begin
                go = 1'b0;
            end
        endcase
        stall = need_pix & ~link.pix_valid;
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        pix_cnt_d = pix_cnt_q;
        sound_d   = sound_q;
        din_d     = din_q;
        we_d      = we_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (low_start) begin
                    sound_d   = link.sound_in;
                    din_d     = sound_slot(link.sound_in, 3'd0);
                    we_d      = 1'b0;
                    slot_d    = '0;
                    pix_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_SOUND;
                end
            end
            ST_SOUND: begin
                if (low_start) begin
                    if (need_pix) begin
                        din_d     = link.pix_data;
                        we_d      = 1'b1;
                        pix_cnt_d = '0;
                        state_d   = ST_PIXELS;
                    end else begin
                        slot_d = slot_q + 1'b1;
                        din_d  = sound_slot(sound_q, 3'(slot_q + 1'b1));
                    end
                end
            end
            ST_PIXELS: begin
                if (slot_end && !need_pix) begin
                    din_d   = '0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (low_start) begin
                    din_d     = link.pix_data;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            pix_cnt_q <= '0;
            sound_q   <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pix_cnt_q <= pix_cnt_d;
            sound_q   <= sound_d;
            din_q     <= din_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign link.pix_ready = need_pix & slot_free;
    assign link.wclk      = wclk;
    assign link.din       = din_q;
    assign link.write_en  = we_q;
    assign link.busy      = busy_q;
    assign link.done      = done_q;

endmodule

// File: tb/tb_vram_link_tx.sv
// Bench for vram_link_tx: small CLK_DIV=2 instance for directed frames,
// full-size CLK_DIV=1 instance feeding a receiver model.
module tb_vram_link_tx;
    import vram_link_pkg::*;

    localparam int NA  = 4;
    localparam int CDA = 2;
    localparam int NB  = LINK_NUM_PIXELS;
    localparam int CDB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vram_link_tx_if ifa ();
    vram_link_tx_if ifb ();

    vram_link_tx #(.NUM_PIXELS(NA), .CLK_DIV(CDA)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .link (ifa)
    );

    vram_link_tx #(.NUM_PIXELS(NB), .CLK_DIV(CDB)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .link (ifb)
    );

    int errors = 0;
    int checks = 0;

    logic [2:0] sb_a[$];
    logic [2:0] sb_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pat(input int i);
        int t;
        t = i + 3 + (i >> 4);
        return t[1:0];
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? ifa.pix_ready : ifb.pix_ready;
    endfunction

    function automatic logic dn(input int d);
        return (d == 0) ? ifa.done : ifb.done;
    endfunction

    function automatic logic [6:0] outs(input int d);
        if (d == 0)
            return {ifa.wclk, ifa.write_en, ifa.busy, ifa.done, ifa.pix_ready, ifa.din};
        return {ifb.wclk, ifb.write_en, ifb.busy, ifb.done, ifb.pix_ready, ifb.din};
    endfunction

    task automatic drv(input int d, input logic s, input logic [15:0] snd,
                       input logic v, input logic [1:0] p);
        if (d == 0) begin
            ifa.start = s; ifa.sound_in = snd; ifa.pix_valid = v; ifa.pix_data = p;
        end else begin
            ifb.start = s; ifb.sound_in = snd; ifb.pix_valid = v; ifb.pix_data = p;
        end
    endtask

    task automatic push(input int d, input logic [2:0] e);
        if (d == 0) sb_a.push_back(e);
        else        sb_b.push_back(e);
    endtask

    // Monitor A: scoreboard on each wclk rise, setup and stall-hold checks.
    logic       pw_a = 1'b0;
    logic       stl_a = 1'b0;
    logic [2:0] prev_a = '0;
    logic [2:0] e_a;
    always @(negedge clk) begin
        if (stl_a) chk("a_stall_hold", {ifa.wclk, ifa.write_en, ifa.din}, {1'b0, prev_a});
        if (ifa.wclk && !pw_a) begin
            chk("a_setup", {ifa.write_en, ifa.din}, prev_a);
            if (sb_a.size() == 0) begin
                chk("a_extra_edge", 1, 0);
            end else begin
                e_a = sb_a.pop_front();
                chk("a_edge", {ifa.write_en, ifa.din}, e_a);
            end
        end
        stl_a  = ifa.pix_ready & ~ifa.pix_valid;
        pw_a   = ifa.wclk;
        prev_a = {ifa.write_en, ifa.din};
    end

    // Monitor B: scoreboard plus a behavioural cartridge receiver.
    logic       pw_b = 1'b0;
    logic [2:0] prev_b = '0;
    logic [2:0] e_b;
    logic [1:0] vram[NB];
    int         maddr = 0;
    logic [15:0] msh = '0;
    logic [15:0] msnd = '0;
    logic       mwe = 1'b0;
    always @(negedge clk) begin
        if (ifb.wclk && !pw_b) begin
            chk("b_setup", {ifb.write_en, ifb.din}, prev_b);
            if (sb_b.size() == 0) begin
                chk("b_extra_edge", 1, 0);
            end else begin
                e_b = sb_b.pop_front();
                chk("b_edge", {ifb.write_en, ifb.din}, e_b);
            end
            if (!ifb.write_en) begin
                maddr = 0;
                msh   = {msh[13:0], ifb.din};
            end else begin
                if (!mwe) msnd = msh;
                if (maddr < NB) vram[maddr] = ifb.din;
                maddr++;
            end
            mwe = ifb.write_en;
        end
        pw_b   = ifb.wclk;
        prev_b = {ifb.write_en, ifb.din};
    end

    // Drives one frame from the start cycle (cycle 0); returns the done cycle.
    task automatic run_frame(input int d, input logic [15:0] snd, input int npix,
                             input int stall_idx, input int stall_len,
                             input int xs1, input int xs2, input int rst_at,
                             output int done_cyc, output int nacc);
        int idx, cyc, left, limit, cd;
        logic fire, s, v;
        logic [15:0] t;
        cd = (d == 0) ? CDA : CDB;
        limit = 1 + (8 + npix) * 2 * cd + stall_len + 50;
        for (int k = 0; k < 8; k++) begin
            t = snd >> (14 - 2 * k);
            push(d, {1'b0, t[1:0]});
        end
        idx = 0; cyc = 0; left = stall_len; done_cyc = -1;
        v = (stall_idx != 0);
        drv(d, 1'b1, snd, v, pat(0));
        while (cyc < limit) begin
            @(negedge clk);
            fire = v & rdy(d);
            if (rdy(d) && !v && left > 0) left--;
            if (dn(d)) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                if (idx < npix) push(d, {1'b1, pat(idx)});
                else chk("extra_pixel_taken", 1, 0);
                idx++;
            end
            if (rst_at >= 0 && idx == rst_at) begin
                rst = 1'b1;
                drv(d, 1'b0, snd, 1'b0, 2'd0);
                if (d == 0) sb_a.delete();
                else        sb_b.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_outputs", outs(d), 0);
                break;
            end
            v = !(idx == stall_idx && left > 0);
            s = (cyc == xs1 || cyc == xs2);
            drv(d, s, s ? ~snd : snd, v, pat(idx));
        end
        nacc = idx;
        @(posedge clk); #1;
        drv(d, 1'b0, snd, 1'b0, 2'd0);
    endtask

    initial begin
        int dc, na, mism;
        rst = 1'b1;
        drv(0, 1'b0, 16'h0, 1'b0, 2'd0);
        drv(1, 1'b0, 16'h0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_reset_state", outs(0), 0);
        chk("b_reset_state", outs(1), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, pixels 3,0,1,2, always valid.
        run_frame(0, 16'hA5C3, NA, -1, 0, -1, -1, -1, dc, na);
        chk("t1_done_cycle", dc, 49);
        chk("t1_pixels", na, NA);
        chk("t1_sb_empty", sb_a.size(), 0);
        repeat (3) @(posedge clk); #1;

        // Ten-cycle stall before pixel 2.
        run_frame(0, 16'h3C96, NA, 2, 10, -1, -1, -1, dc, na);
        chk("t2_done_cycle", dc, 59);
        chk("t2_sb_empty", sb_a.size(), 0);
        repeat (3) @(posedge clk); #1;

        // start mid-sound and in the DONE cycle must be ignored.
        run_frame(0, 16'h1234, NA, -1, 0, 10, 49, -1, dc, na);
        chk("t3_done_cycle", dc, 49);
        @(negedge clk);
        chk("t3_busy_after_done", ifa.busy, 0);
        chk("t3_sb_empty", sb_a.size(), 0);
        repeat (2) @(posedge clk); #1;

        // Back-to-back frames: second start the cycle after done.
        run_frame(0, 16'h0F0F, NA, -1, 0, -1, -1, -1, dc, na);
        chk("t4a_done_cycle", dc, 49);
        run_frame(0, 16'hF00F, NA, -1, 0, -1, -1, -1, dc, na);
        chk("t4b_done_cycle", dc, 49);
        chk("t4_sb_empty", sb_a.size(), 0);

        // Full-size instance: abort after pixel 100, then a full frame.
        run_frame(1, 16'h8421, NB, -1, 0, -1, -1, 101, dc, na);
        chk("t5_abort_pixels", na, 101);
        repeat (20) @(negedge clk);
        chk("t5_idle_after_rst", outs(1), 0);
        @(posedge clk); #1;
        run_frame(1, 16'h7E81, NB, -1, 0, -1, -1, -1, dc, na);
        chk("t6_done_cycle", dc, 1 + (8 + NB) * 2);
        chk("t6_sb_empty", sb_b.size(), 0);
        chk("t6_model_addr", maddr, NB);
        chk("t6_model_sound", msnd, 16'h7E81);
        mism = 0;
        for (int i = 0; i < NB; i++)
            if (vram[i] !== pat(i)) mism++;
        chk("t6_vram_mismatches", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
